pio_osr: RTL and testbench
==========================

# pio_osr

Output shift register (OSR) for a PIO state machine, sitting directly downstream of the TX FIFO. It pops 32-bit words from the FIFO, explicitly on a pull request or automatically when the shift-count threshold is reached. It then shifts 1–32 bits per request toward the state machine's output path. It owns the FIFO pop handshake and the stall signal back to the instruction sequencer.

## Interface
Parameters:
- None. The datapath is fixed at 32 bits.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_data`  in  32  TX FIFO registered read data; valid the cycle after a successful pop.
- `fifo_stat`  in  `fifo_status`  TX FIFO `{empty, full}`.
- `fifo_pop`  out  1  pop strobe to the FIFO; combinational; asserted only when `!fifo_stat.empty`.
- `cfg_shift_right`  in  1  1 = LSB shifted out first; 0 = MSB shifted out first.
- `cfg_autopull`  in  1  enables automatic refill.
- `cfg_pull_thresh`  in  5  autopull threshold in bits; 0 encodes 32.
- `out_req`  in  1  request to shift out `out_count` bits; held while `stall`.
- `out_count`  in  5  bits to shift; 0 encodes 32.
- `pull_req`  in  1  explicit pull; held while `stall`.
- `pull_block`  in  1  1 = a pull stalls on an empty FIFO; 0 = a pull loads zero.
- `stall`  out  1  combinational; the current request did not complete this cycle.
- `out_data`  out  32  shifted bits, right-aligned, zero-extended; registered.
- `out_valid`  out  1  one-cycle pulse qualifying `out_data`.
- `osr_count`  out  6  bits consumed since the last load, 0..32.

## Operation
- State: `osr[31:0]` and `count[5:0]`. `count` = 32 means the OSR is empty.
- FSM states:
  - READY: normal operation.
  - FETCH: a pop was issued in the previous cycle. Capture `fifo_data` into `osr`, set `count` to 0, return to READY.
- Effective threshold: T = (`cfg_pull_thresh` == 0) ? 32 : `cfg_pull_thresh`. Define need_pull = `cfg_autopull` && `count` >= T.
- READY priority, highest first:
  1. `pull_req`:
     - FIFO non-empty: `fifo_pop`=1, `stall`=1, go to FETCH.
     - FIFO empty and `pull_block`=1: `stall`=1, stay in READY.
     - FIFO empty and `pull_block`=0: `osr` ← 0, `count` ← 0, `stall`=0.
  2. `out_req` with need_pull:
     - FIFO non-empty: `fifo_pop`=1, `stall`=1, go to FETCH.
     - FIFO empty: `stall`=1.
  3. `out_req` otherwise: shift n bits (n = `out_count`, 0 maps to 32), `stall`=0.
     - Right shift: data = `osr[n-1:0]`; `osr` ← `osr` >> n.
     - Left shift: data = `osr[31:32-n]`; `osr` ← `osr` << n.
     - Vacated bits fill with zero.
     - `count` ← min(`count` + n, 32). Saturation: an over-shift returns zero bits beyond the loaded data.
  4. No request, need_pull, FIFO non-empty: background refill. `fifo_pop`=1, go to FETCH.
- FETCH behaviour:
  - `stall`=1 for any `out_req`.
  - A held `pull_req` completes with `stall`=0.
  - No pop is issued in FETCH.
- `pull_req` and `out_req` asserted together: the pull wins and the out stalls.
- Configuration inputs are sampled every cycle and are static in practice.

## Timing
- Reset values: `osr`=0, `count`=32, state READY, `out_data`=0, `out_valid`=0. `fifo_pop` and `stall` are combinationally 0 while `rst` is asserted.
- Out without refill:
  - `stall`=0 in the request cycle.
  - `out_data`/`out_valid` appear on the next edge.
- Explicit pull:
  - Cycle 0: pop issued, `stall`=1.
  - Cycle 1 (FETCH): load occurs, `stall`=0.
  - Total 2 cycles.
- Out requiring refill: pop, FETCH, then the shift completes in cycle 2. Results are visible in cycle 3.
- FIFO empty with a blocking stall: completion occurs 2 cycles after the FIFO becomes non-empty.
- `osr_count` reflects the registered `count` and updates on the completion edge.
- Reset during FETCH: return to READY with `count`=32. The popped word is discarded, because the FIFO has already advanced.

## Structure
- Shared package `pio_pkg`:
  - `fifo_status` typedef, moved there and shared with the FIFO.
  - `osr_state_e` enum (READY, FETCH).
  - Constant `PIO_WORD_W` = 32.
- One combinational sub-module, `osr_shifter`:
  - Inputs: `osr`, n, direction.
  - Outputs: extracted data and the shifted register.
  - Must handle n = 32 without width overflow.
- The FSM, counter and handshake logic live in `pio_osr`.

## Test plan
- Reset: release `rst` → `osr_count`=32, `out_valid`=0, `fifo_pop`=0, `stall`=0 with no requests.
- Explicit pull of 0xDEADBEEF, `cfg_shift_right`=1, two `out_req` of 8 bits → `out_data` 0xEF then 0xBE; `osr_count` 8 then 16.
- Same word, `cfg_shift_right`=0, `out_count`=4 then `out_count`=0 → `out_data` 0xD, then 0xEADBEEF0; `osr_count` 32.
- Autopull with threshold 0 (32) and FIFO holding 0x11111111, 0x22222222; four `out_req` of 16 bits, LSB-first → outputs 0x1111, 0x1111, 0x2222, 0x2222; stall cycles only at the pops.
- Autopull on, FIFO empty, `out_req` held → `stall`=1 and no pop. Push 0xA5 → pop the next cycle, completion 2 cycles later, `out_data`=0x5 for `out_count`=4.
- Non-blocking `pull_req` on an empty FIFO → `stall`=0 and `osr_count`=0. A subsequent 32-bit out gives 0. Over-shift of 8 bits at count 28 gives zero-filled data and `osr_count`=32.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared PIO definitions: TX FIFO status, OSR sequencer states and word width.
package pio_pkg;

  localparam int PIO_WORD_W = 32;

  typedef struct packed {
    logic empty;
    logic full;
  } fifo_status;

  typedef enum logic {
    READY = 1'b0,
    FETCH = 1'b1
  } osr_state_e;

endpackage

// File: rtl/osr_shifter.sv
// Combinational extract-and-shift for the OSR; n is 1..32 and n = 32 empties the register.
module osr_shifter
  import pio_pkg::*;
(
  input  logic [PIO_WORD_W-1:0] osr,
  input  logic [5:0]            n,
  input  logic                  shift_right,
  output logic [PIO_WORD_W-1:0] data,
  output logic [PIO_WORD_W-1:0] shifted
);

  // A double-width window lets n = 32 move every bit out without an oversized shift.
  logic [2*PIO_WORD_W-1:0] wide;
  logic [5:0]              back;

  always_comb begin
    wide    = '0;
    back    = 6'd32 - n;
    data    = '0;
    shifted = '0;
    if (shift_right) begin
      wide    = {osr, {PIO_WORD_W{1'b0}}} >> n;
      shifted = wide[2*PIO_WORD_W-1:PIO_WORD_W];
      data    = wide[PIO_WORD_W-1:0] >> back;
    end else begin
      wide    = {{PIO_WORD_W{1'b0}}, osr} << n;
      shifted = wide[PIO_WORD_W-1:0];
      data    = wide[2*PIO_WORD_W-1:PIO_WORD_W];
    end
  end

endmodule

// File: rtl/pio_osr.sv
// PIO output shift register: owns the TX FIFO pop handshake, autopull and the
// sequencer stall, and shifts 1..32 bits per out request.
module pio_osr
  import pio_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIO_WORD_W-1:0] fifo_data,
  input  fifo_status            fifo_stat,
  output logic                  fifo_pop,
  input  logic                  cfg_shift_right,
  input  logic                  cfg_autopull,
  input  logic [4:0]            cfg_pull_thresh,
  input  logic                  out_req,
  input  logic [4:0]            out_count,
  input  logic                  pull_req,
  input  logic                  pull_block,
  output logic                  stall,
  output logic [PIO_WORD_W-1:0] out_data,
  output logic                  out_valid,
  output logic [5:0]            osr_count
);

  // Handshakes: a request (out_req / pull_req) completes in the cycle stall is
  // low and is held by the sequencer while stall is high. fifo_pop is a
  // one-cycle strobe only when the FIFO is not empty; fifo_data is valid the
  // following cycle, which is always spent in FETCH.
  osr_state_e            state_q;
  logic [PIO_WORD_W-1:0] osr_q;
  logic [5:0]            count_q;

  logic [5:0]            thresh;
  logic [5:0]            n;
  logic                  need_pull;
  logic                  go_fetch;
  logic                  do_zero;
  logic                  do_shift;
  logic [6:0]            count_sum;
  logic [PIO_WORD_W-1:0] sh_data;
  logic [PIO_WORD_W-1:0] sh_osr;
  logic                  unused_full;

  assign unused_full = fifo_stat.full;
  assign thresh      = (cfg_pull_thresh == 5'd0) ? 6'd32 : {1'b0, cfg_pull_thresh};
  assign n           = (out_count == 5'd0) ? 6'd32 : {1'b0, out_count};
  assign need_pull   = cfg_autopull && (count_q >= thresh);
  assign count_sum   = {1'b0, count_q} + {1'b0, n};
  assign osr_count   = count_q;

  osr_shifter u_shifter (
    .osr         (osr_q),
    .n           (n),
    .shift_right (cfg_shift_right),
    .data        (sh_data),
    .shifted     (sh_osr)
  );

  always_comb begin
    fifo_pop = 1'b0;
    stall    = 1'b0;
    go_fetch = 1'b0;
    do_zero  = 1'b0;
    do_shift = 1'b0;
    if (!rst) begin
      if (state_q == FETCH) begin
        stall = out_req;
      end else if (pull_req) begin
        if (!fifo_stat.empty) begin
          fifo_pop = 1'b1;
          stall    = 1'b1;
          go_fetch = 1'b1;
        end else if (pull_block) begin
          stall = 1'b1;
        end else begin
          do_zero = 1'b1;
        end
      end else if (out_req && need_pull) begin
        stall = 1'b1;
        if (!fifo_stat.empty) begin
          fifo_pop = 1'b1;
          go_fetch = 1'b1;
        end
      end else if (out_req) begin
        do_shift = 1'b1;
      end else if (need_pull && !fifo_stat.empty) begin
        fifo_pop = 1'b1;
        go_fetch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= READY;
      osr_q     <= '0;
      count_q   <= 6'd32;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        FETCH: begin
          osr_q   <= fifo_data;
          count_q <= 6'd0;
          state_q <= READY;
        end
        default: begin
          if (go_fetch) begin
            state_q <= FETCH;
          end else if (do_zero) begin
            osr_q   <= '0;
            count_q <= 6'd0;
          end else if (do_shift) begin
            osr_q     <= sh_osr;
            count_q   <= (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];
            out_data  <= sh_data;
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_osr.sv
// Bench for pio_osr: FIFO model, per-cycle word/consumed-bits reference model, literal scoreboard.
module tb_pio_osr;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fifo_data = '0;
  fifo_status  fifo_stat;
  logic        fifo_pop;
  logic        cfg_shift_right = 1'b1;
  logic        cfg_autopull = 1'b0;
  logic [4:0]  cfg_pull_thresh = 5'd0;
  logic        out_req = 1'b0;
  logic [4:0]  out_count = 5'd0;
  logic        pull_req = 1'b0;
  logic        pull_block = 1'b1;
  logic        stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic [5:0]  osr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_q[$];
  logic        q_empty = 1'b1;
  assign fifo_stat = {q_empty, 1'b0};

  logic [31:0] exp_q[$];
  logic [5:0]  exp_cnt_q[$];

  pio_osr dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_data       (fifo_data),
    .fifo_stat       (fifo_stat),
    .fifo_pop        (fifo_pop),
    .cfg_shift_right (cfg_shift_right),
    .cfg_autopull    (cfg_autopull),
    .cfg_pull_thresh (cfg_pull_thresh),
    .out_req         (out_req),
    .out_count       (out_count),
    .pull_req        (pull_req),
    .pull_block      (pull_block),
    .stall           (stall),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .osr_count       (osr_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // TX FIFO model: registered read data the cycle after a pop
  always @(posedge clk) begin
    if (!rst && fifo_pop && fifo_q.size() > 0) begin
      fifo_data <= fifo_q.pop_front();
      q_empty   <= (fifo_q.size() == 0);
    end
  end

  // Reference model: loaded word plus number of bits already consumed.
  logic [31:0] m_w = '0;
  int          m_c = 32;
  bit          m_fetch = 0;
  logic [31:0] m_pend = '0;
  bit          m_v = 0;
  logic [31:0] m_d = '0;
  logic [31:0] s_w, s_pend, s_d;
  int          s_c;
  bit          s_fetch, s_v;

  function automatic logic [31:0] extract(input logic [31:0] w, input int c, input int n,
                                          input bit right);
    logic [63:0] x;
    if (right) begin
      x = {32'b0, w} >> c;
      x = x & ((64'd1 << n) - 64'd1);
    end else begin
      x = ({32'b0, w} << c) & 64'hFFFF_FFFF;
      x = x >> (32 - n);
    end
    return x[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      int  t, n;
      bit  need, nonempty, e_stall, e_pop;
      t        = (cfg_pull_thresh == 0) ? 32 : int'(cfg_pull_thresh);
      n        = (out_count == 0) ? 32 : int'(out_count);
      need     = cfg_autopull && (m_c >= t);
      nonempty = fifo_q.size() > 0;
      e_stall  = 0;
      e_pop    = 0;
      s_w = m_w; s_c = m_c; s_fetch = 0; s_pend = m_pend; s_v = 0; s_d = m_d;
      if (m_fetch) begin
        e_stall = out_req;
        s_w = m_pend;
        s_c = 0;
      end else if (pull_req) begin
        if (nonempty) begin
          e_pop = 1; e_stall = 1; s_fetch = 1; s_pend = fifo_q[0];
        end else if (pull_block) begin
          e_stall = 1;
        end else begin
          s_w = '0; s_c = 0;
        end
      end else if (out_req && need) begin
        e_stall = 1;
        if (nonempty) begin
          e_pop = 1; s_fetch = 1; s_pend = fifo_q[0];
        end
      end else if (out_req) begin
        s_v = 1;
        s_d = extract(m_w, m_c, n, cfg_shift_right);
        s_c = (m_c + n > 32) ? 32 : m_c + n;
      end else if (need && nonempty) begin
        e_pop = 1; s_fetch = 1; s_pend = fifo_q[0];
      end
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("fifo_pop", {31'b0, fifo_pop}, {31'b0, e_pop});
      chk("osr_count", {26'b0, osr_count}, m_c);
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
      if (m_v) chk("out_data", out_data, m_d);
      if (out_valid && exp_q.size() > 0) begin
        chk("lit_data", out_data, exp_q.pop_front());
        chk("lit_count", {26'b0, osr_count}, {26'b0, exp_cnt_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_w = '0; m_c = 32; m_fetch = 0; m_v = 0; m_d = '0;
    end else begin
      m_w = s_w; m_c = s_c; m_fetch = s_fetch; m_pend = s_pend; m_v = s_v; m_d = s_d;
    end
  end

  // driver tasks
  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    q_empty = 1'b0;
  endtask

  task automatic add_exp(input logic [31:0] d, input logic [5:0] c);
    exp_q.push_back(d);
    exp_cnt_q.push_back(c);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (stall && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk({name, "_timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_out(input logic [4:0] cnt);
    out_req   = 1'b1;
    out_count = cnt;
    wait_done("out");
    out_req = 1'b0;
  endtask

  task automatic do_pull();
    pull_req = 1'b1;
    wait_done("pull");
    pull_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", {26'b0, osr_count}, 32'd32);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pop", {31'b0, fifo_pop}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    @(posedge clk); #1;

    // explicit pull, LSB first
    push(32'hDEADBEEF);
    do_pull();
    add_exp(32'hEF, 6'd8);  do_out(5'd8);
    add_exp(32'hBE, 6'd16); do_out(5'd8);

    // explicit pull, MSB first, then a 32-bit over-shift
    cfg_shift_right = 1'b0;
    push(32'hDEADBEEF);
    do_pull();
    add_exp(32'hD, 6'd4);          do_out(5'd4);
    add_exp(32'hEADBEEF0, 6'd32);  do_out(5'd0);

    // autopull at threshold 32
    cfg_shift_right = 1'b1;
    push(32'h11111111);
    push(32'h22222222);
    cfg_autopull = 1'b1;
    add_exp(32'h1111, 6'd16); do_out(5'd16);
    add_exp(32'h1111, 6'd32); do_out(5'd16);
    add_exp(32'h2222, 6'd16); do_out(5'd16);
    add_exp(32'h2222, 6'd32); do_out(5'd16);

    // autopull stalls on an empty FIFO until a word arrives
    add_exp(32'h5, 6'd4);
    fork
      do_out(5'd4);
      begin
        repeat (3) @(posedge clk);
        #2 push(32'hA5);
      end
    join

    // non-blocking pull on empty FIFO, then over-shift
    cfg_autopull = 1'b0;
    pull_block   = 1'b0;
    do_pull();
    chk("nb_pull_count", {26'b0, osr_count}, 32'd0);
    add_exp(32'h0, 6'd32); do_out(5'd0);
    pull_block = 1'b1;
    push(32'hCAFEF00D);
    do_pull();
    add_exp(32'h0AFEF00D, 6'd28); do_out(5'd28);
    add_exp(32'hC, 6'd32);        do_out(5'd8);

    // reset while in FETCH drops the popped word
    push(32'h12345678);
    pull_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    pull_req = 1'b0;
    #1;
    chk("rst_fetch_pop", {31'b0, fifo_pop}, 32'd0);
    chk("rst_fetch_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fetch_count", {26'b0, osr_count}, 32'd32);
    @(posedge clk); #1;
    add_exp(32'h0, 6'd32); do_out(5'd8);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
